// File: rtl/vga_bounce_sprites.sv
`default_nettype none
// ============================================================================
// vga_bounce_sprites: three bouncing squares, hit-tested per pixel strobe.
// Option macro VGA_BOUNCE_OVERLAP_MIX_EN mixes overlapping squares additively.
// Revision: 1.0
// ============================================================================
module vga_bounce_sprites #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int SIZE  = 80,
  parameter int STEP  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pix_strb_i,
  input  logic       active_i,
  input  logic       animate_i,
  input  logic [9:0] x_i,
  input  logic [8:0] y_i,
  output logic [3:0] red_o,
  output logic [3:0] green_o,
  output logic [3:0] blue_o
);

  localparam logic [10:0] MAX_X  = 11'(H_RES - SIZE);
  localparam logic [10:0] MAX_Y  = 11'(V_RES - SIZE);
  localparam logic [10:0] SIZE_W = 11'(SIZE);
  localparam logic [10:0] STEP_W = 11'(STEP);

  // Square 0 = red, 1 = green, 2 = blue
  localparam logic [29:0] RST_PX = {10'd520, 10'd100, 10'd40};
  localparam logic [26:0] RST_PY = {9'd360, 9'd100, 9'd40};
  localparam logic [2:0]  RST_DX = 3'b011;
  localparam logic [2:0]  RST_DY = 3'b001;

  logic        move;
  logic [10:0] x_w;
  logic [10:0] y_w;
  logic [2:0]  hit;

  assign move = animate_i && pix_strb_i;
  assign x_w  = {1'b0, x_i};
  assign y_w  = {2'b00, y_i};

  for (genvar i = 0; i < 3; i++) begin : g_sq
    logic [9:0]  px_q, px_d;
    logic [8:0]  py_q, py_d;
    logic        dx_q, dx_d, dy_q, dy_d;
    logic [10:0] px_w, py_w, px_up, py_up;

    assign px_w  = {1'b0, px_q};
    assign py_w  = {2'b00, py_q};
    assign px_up = px_w + STEP_W;
    assign py_up = py_w + STEP_W;

    // Edge handling clamps to the limit rather than overshooting, then reverses
    always_comb begin
      px_d = px_q;
      py_d = py_q;
      dx_d = dx_q;
      dy_d = dy_q;
      if (move) begin
        if (dx_q) begin
          if (px_up >= MAX_X) begin
            px_d = MAX_X[9:0];
            dx_d = 1'b0;
          end else begin
            px_d = px_up[9:0];
          end
        end else if (px_w <= STEP_W) begin
          px_d = '0;
          dx_d = 1'b1;
        end else begin
          px_d = px_q - STEP_W[9:0];
        end

        if (dy_q) begin
          if (py_up >= MAX_Y) begin
            py_d = MAX_Y[8:0];
            dy_d = 1'b0;
          end else begin
            py_d = py_up[8:0];
          end
        end else if (py_w <= STEP_W) begin
          py_d = '0;
          dy_d = 1'b1;
        end else begin
          py_d = py_q - STEP_W[8:0];
        end
      end
    end

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        px_q <= RST_PX[i*10 +: 10];
        py_q <= RST_PY[i*9 +: 9];
        dx_q <= RST_DX[i];
        dy_q <= RST_DY[i];
      end else begin
        px_q <= px_d;
        py_q <= py_d;
        dx_q <= dx_d;
        dy_q <= dy_d;
      end
    end

    assign hit[i] = (x_w >= px_w) && (x_w < px_w + SIZE_W) &&
                    (y_w >= py_w) && (y_w < py_w + SIZE_W);
  end

  logic [3:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

  always_comb begin
    red_d   = red_q;
    green_d = green_q;
    blue_d  = blue_q;
    if (pix_strb_i) begin
      red_d   = 4'h0;
      green_d = 4'h0;
      blue_d  = 4'h0;
      if (active_i) begin
`ifdef VGA_BOUNCE_OVERLAP_MIX_EN
        red_d   = {4{hit[0]}};
        green_d = {4{hit[1]}};
        blue_d  = {4{hit[2]}};
`else
        if (hit[0])      red_d   = 4'hF;
        else if (hit[1]) green_d = 4'hF;
        else if (hit[2]) blue_d  = 4'hF;
`endif
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      red_q   <= 4'h0;
      green_q <= 4'h0;
      blue_q  <= 4'h0;
    end else begin
      red_q   <= red_d;
      green_q <= green_d;
      blue_q  <= blue_d;
    end
  end

  assign red_o   = red_q;
  assign green_o = green_q;
  assign blue_o  = blue_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_bounce_sprites.sv
`default_nettype none
// Testbench for vga_bounce_sprites: directed bounce/clamp scenarios plus
// randomized pixel traffic against a frame-level reference model.
module tb_vga_bounce_sprites;
  localparam int SIZE = 80;
  localparam int STEP = 2;
  localparam int MAXX = 560;
  localparam int MAXY = 400;

  logic       clk = 1'b0;
  logic       reset;
  logic       pix_strb_i, active_i, animate_i;
  logic [9:0] x_i;
  logic [8:0] y_i;
  logic [3:0] red_o, green_o, blue_o;

  int checks = 0;
  int failures = 0;

  // Reference model state: index 0 red, 1 green, 2 blue
  int mpx[3], mpy[3], mdx[3], mdy[3];
  logic [3:0] er, eg, eb;

  vga_bounce_sprites dut (
    .clk(clk), .reset(reset), .pix_strb_i(pix_strb_i), .active_i(active_i),
    .animate_i(animate_i), .x_i(x_i), .y_i(y_i),
    .red_o(red_o), .green_o(green_o), .blue_o(blue_o)
  );

  always #5 clk = ~clk;

  function automatic void model_reset();
    mpx = '{40, 100, 520};
    mpy = '{40, 100, 360};
    mdx = '{1, 1, 0};
    mdy = '{1, 0, 0};
    er = 4'h0; eg = 4'h0; eb = 4'h0;
  endfunction

  function automatic void axis(inout int pos, inout int dir, input int lim);
    if (dir == 1) begin
      if (pos + STEP >= lim) begin pos = lim; dir = 0; end
      else pos = pos + STEP;
    end else begin
      if (pos <= STEP) begin pos = 0; dir = 1; end
      else pos = pos - STEP;
    end
  endfunction

  function automatic void model_move();
    for (int k = 0; k < 3; k++) begin
      axis(mpx[k], mdx[k], MAXX);
      axis(mpy[k], mdy[k], MAXY);
    end
  endfunction

  function automatic void model_pixel(input int x, input int y, input bit act);
    bit h[3];
    for (int k = 0; k < 3; k++)
      h[k] = (x >= mpx[k]) && (x < mpx[k] + SIZE) && (y >= mpy[k]) && (y < mpy[k] + SIZE);
    er = 4'h0; eg = 4'h0; eb = 4'h0;
    if (act) begin
`ifdef VGA_BOUNCE_OVERLAP_MIX_EN
      if (h[0]) er = 4'hF;
      if (h[1]) eg = 4'hF;
      if (h[2]) eb = 4'hF;
`else
      if (h[0]) er = 4'hF;
      else if (h[1]) eg = 4'hF;
      else if (h[2]) eb = 4'hF;
`endif
    end
  endfunction

  // One clk cycle of stimulus; model follows the same edge
  task automatic cyc(input int x, input int y, input bit act, input bit anim, input bit strb);
    @(negedge clk);
    x_i = 10'(x); y_i = 9'(y);
    active_i = act; animate_i = anim; pix_strb_i = strb;
    @(posedge clk);
    if (strb) begin
      model_pixel(int'(x_i), int'(y_i), act);
      if (anim) model_move();
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; pix_strb_i = 0; active_i = 0; animate_i = 0; x_i = '0; y_i = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== 12'h000) begin
      failures++;
      $display("FAIL reset_state got=%h want=000", {red_o, green_o, blue_o});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_hit_basic();
    int pts[4][3] = '{'{40, 40, 1}, '{40, 40, 0}, '{39, 40, 1}, '{119, 119, 1}};
    for (int i = 0; i < 4; i++) begin
      cyc(pts[i][0], pts[i][1], pts[i][2] != 0, 0, 1);
      checks++;
      if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL hit_basic[%0d] got=%h want=%h", i, {red_o, green_o, blue_o}, {er, eg, eb});
      end
    end
  endtask

  task automatic test_overlap();
    cyc(110, 110, 1, 0, 1);
    checks++;
    if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
      failures++;
      $display("FAIL overlap got=%h want=%h", {red_o, green_o, blue_o}, {er, eg, eb});
    end
  endtask

  task automatic test_move();
    // stimulus: x, y, active, animate, strobe
    int st[7][5] = '{'{0, 0, 0, 1, 1}, '{41, 41, 1, 0, 1}, '{42, 42, 1, 0, 1},
                     '{42, 42, 1, 1, 0}, '{42, 42, 1, 0, 0}, '{43, 43, 1, 0, 1},
                     '{41, 41, 1, 0, 1}};
    do_reset();
    for (int i = 0; i < 7; i++) begin
      cyc(st[i][0], st[i][1], st[i][2] != 0, st[i][3] != 0, st[i][4] != 0);
      checks++;
      if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL move[%0d] got=%h want=%h", i, {red_o, green_o, blue_o}, {er, eg, eb});
      end
    end
  endtask

  task automatic test_bounce();
    int ry;
    do_reset();
    for (int n = 1; n <= 260; n++) cyc($urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 1);
    ry = mpy[0] + 1;
    cyc(639, ry, 1, 0, 1);
    checks++;
    if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
      failures++;
      $display("FAIL bounce_right_edge got=%h want=%h", {red_o, green_o, blue_o}, {er, eg, eb});
    end
    cyc(560, ry, 1, 1, 1);
    ry = mpy[0] + 1;
    for (int i = 0; i < 3; i++) begin
      int xs[3] = '{638, 637, 558};
      cyc(xs[i], ry, 1, 0, 1);
      checks++;
      if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL bounce_back x=%0d got=%h want=%h", xs[i], {red_o, green_o, blue_o}, {er, eg, eb});
      end
    end
  endtask

  task automatic test_corner();
    int xo[4] = '{-1, 0, SIZE - 1, SIZE};
    int yo[4] = '{0, SIZE - 1, 0, SIZE};
    int marks[4] = '{50, 51, 180, 260};
    int done = 0;
    do_reset();
    for (int m = 0; m < 4; m++) begin
      while (done < marks[m]) begin
        cyc($urandom_range(0, 639), $urandom_range(0, 479), $urandom_range(0, 1) != 0, 1, 1);
        done++;
      end
      for (int k = 0; k < 3; k++)
        for (int p = 0; p < 4; p++) begin
          cyc(mpx[k] + xo[p], mpy[k] + yo[p], 1, 0, 1);
          checks++;
          if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
            failures++;
            $display("FAIL corner ev=%0d sq=%0d pt=%0d got=%h want=%h",
                     done, k, p, {red_o, green_o, blue_o}, {er, eg, eb});
          end
        end
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int n = 0; n < 30; n++) cyc($urandom_range(0, 639), $urandom_range(0, 479), 1, 1, 1);
    cyc(mpx[0], mpy[0], 1, 0, 1);
    reset = 1'b1;
    model_reset();
    #1;
    checks++;
    if ({red_o, green_o, blue_o} !== 12'h000) begin
      failures++;
      $display("FAIL async_reset_outputs got=%h want=000", {red_o, green_o, blue_o});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      int xs[3] = '{40, 39, 119};
      cyc(xs[i], 40, 1, 0, 1);
      checks++;
      if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL async_reset_resume x=%0d got=%h want=%h", xs[i], {red_o, green_o, blue_o}, {er, eg, eb});
      end
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 800; n++) begin
      bit strb = $urandom_range(0, 3) != 0;
      bit anim = $urandom_range(0, 2) == 0;
      cyc($urandom_range(0, 700), $urandom_range(0, 511), $urandom_range(0, 4) != 0, anim, strb);
      checks++;
      if ({red_o, green_o, blue_o} !== {er, eg, eb}) begin
        failures++;
        $display("FAIL random[%0d] got=%h want=%h", n, {red_o, green_o, blue_o}, {er, eg, eb});
      end
    end
  endtask

  initial begin
    test_reset();
    test_hit_basic();
    test_overlap();
    test_move();
    test_bounce();
    test_corner();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
